// File: rtl/nb_recur_pkg.sv
// nb_recur_pkg: shared state encoding, mode constants and saturation limits for nb_recurrence_unit
package nb_recur_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] sat_limit(input int w, input logic neg);
    logic [MAX_W-1:0] hi;
    hi = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    return neg ? ~hi : hi;
  endfunction
endpackage

// File: rtl/nb_sat_addsub.sv
// nb_sat_addsub: W-bit signed add/subtract with wrap or saturate and an overflow flag
module nb_sat_addsub
  import nb_recur_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  input  logic         sat_mode,
  output logic [W-1:0] res,
  output logic         ovf
);
  localparam logic [MAX_W-1:0] HI = sat_limit(W, 1'b0);
  localparam logic [MAX_W-1:0] LO = sat_limit(W, 1'b1);
  logic [W:0] xe, ye, sum;
  assign xe = {x[W-1], x};
  assign ye = {y[W-1], y};
  assign sum = sub ? xe - ye : xe + ye;
  assign ovf = sum[W] ^ sum[W-1];
  assign res = (ovf && sat_mode == MODE_SAT) ? (sum[W] ? LO[W-1:0] : HI[W-1:0]) : sum[W-1:0];
endmodule

// File: rtl/nb_recurrence_unit.sv
// nb_recurrence_unit: four-register coupled recurrence with load handshake, iteration count, pause and saturation
module nb_recurrence_unit
  import nb_recur_pkg::*;
#(
  parameter int W = 32,
  parameter int CNT_W = 16,
  parameter int K_D = 3,
  parameter int K_B = 10,
  parameter int STEP = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  input  logic [W-1:0]     c0,
  input  logic [W-1:0]     d0,
  input  logic [CNT_W-1:0] n_iter,
  input  logic             sat_mode,
  input  logic             enable,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [W-1:0]     c,
  output logic [W-1:0]     d,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [CNT_W-1:0] iter
);
  localparam logic [W-1:0] KD = W'(K_D);
  localparam logic [W-1:0] KB = W'(K_B);
  localparam logic [W-1:0] ST = W'(STEP);
  state_t state, state_nx;
  logic [CNT_W-1:0] n_lat;
  logic mode, accept, step, last;
  logic [W-1:0] a_nx, b_nx, c_nx, d_nx;
  logic [3:0] o;
  assign accept = start_valid && start_ready;
  assign step = state == RUN && enable;
  assign last = iter + CNT_W'(1) == n_lat;
  // every update reads only the old register values, so the four units run side by side
  nb_sat_addsub #(.W(W)) u_a (.x(b), .y(c),  .sub(1'b0), .sat_mode(mode), .res(a_nx), .ovf(o[0]));
  nb_sat_addsub #(.W(W)) u_d (.x(a), .y(KD), .sub(1'b1), .sat_mode(mode), .res(d_nx), .ovf(o[1]));
  nb_sat_addsub #(.W(W)) u_b (.x(d), .y(KB), .sub(1'b0), .sat_mode(mode), .res(b_nx), .ovf(o[2]));
  nb_sat_addsub #(.W(W)) u_c (.x(c), .y(ST), .sub(1'b0), .sat_mode(mode), .res(c_nx), .ovf(o[3]));
  always_ff @(posedge clock)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = accept ? ((n_iter != '0) ? RUN : DONE)
             : (state == RUN) ? ((step && last) ? DONE : RUN)
             : IDLE;
  always_comb begin
    start_ready = state != RUN;
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clock)
    if (!reset_n) begin
      {a, b, c, d} <= '0;
      iter <= '0;
      n_lat <= '0;
      ovf <= 1'b0;
      mode <= MODE_WRAP;
    end else if (accept) begin
      {a, b, c, d} <= {a0, b0, c0, d0};
      iter <= '0;
      n_lat <= n_iter;
      ovf <= 1'b0;
      mode <= sat_mode;
    end else if (step) begin
      {a, b, c, d} <= {a_nx, b_nx, c_nx, d_nx};
      iter <= iter + CNT_W'(1);
      ovf <= ovf | (|o);
    end
endmodule

// File: tb/tb_nb_recurrence_unit.sv
// tb_nb_recurrence_unit: directed checks of nb_recurrence_unit at W=32 and W=8
module tb_nb_recurrence_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start_valid = 1'b0, sat_mode = 1'b0, enable = 1'b1;
  logic [31:0] a0 = '0, b0 = '0, c0 = '0, d0 = '0, a, b, c, d;
  logic [15:0] n_iter = '0, iter;
  logic start_ready, busy, done, ovf;
  logic sv8 = 1'b0, sm8 = 1'b0;
  logic [7:0] a8, b8, c8, d8;
  logic [15:0] n8 = 16'd1, iter8;
  logic sr8, busy8, done8, ovf8;
  int n_checks = 0, n_fail = 0;

  always #5 clock = ~clock;

  nb_recurrence_unit dut (
    .clock(clock), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
    .a0(a0), .b0(b0), .c0(c0), .d0(d0), .n_iter(n_iter), .sat_mode(sat_mode), .enable(enable),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .ovf(ovf), .iter(iter)
  );

  nb_recurrence_unit #(.W(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start_valid(sv8), .start_ready(sr8),
    .a0(8'd0), .b0(8'd100), .c0(8'd100), .d0(8'd0), .n_iter(n8), .sat_mode(sm8), .enable(1'b1),
    .a(a8), .b(b8), .c(c8), .d(d8), .busy(busy8), .done(done8), .ovf(ovf8), .iter(iter8)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input int ea, input int eb, input int ec, input int ed);
    chk({tag, ".abcd"}, {a, b}, {32'(ea), 32'(eb)});
    chk({tag, ".cd"}, {c, d}, {32'(ec), 32'(ed)});
  endtask

  task automatic seed(input int sa, input int sb, input int sc, input int sd, input int n);
    a0 = 32'(sa); b0 = 32'(sb); c0 = 32'(sc); d0 = 32'(sd); n_iter = 16'(n);
  endtask

  initial begin
    tick();
    reset_n = 1'b1;
    chk_regs("reset", 0, 0, 0, 0);
    chk("reset.flags", {busy, done, ovf, start_ready, iter}, {4'b0001, 16'd0});

    // basic run
    seed(30, 20, 15, 5, 3);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk_regs("s1.seed", 30, 20, 15, 5);
    chk("s1.busy", {busy, start_ready}, 2'b10);
    tick();
    chk_regs("s1.u1", 35, 15, 16, 27);
    chk("s1.iter1", iter, 16'd1);
    tick();
    chk_regs("s1.u2", 31, 37, 17, 32);
    tick();
    chk_regs("s1.u3", 54, 42, 18, 28);
    chk("s1.done", {done, busy, ovf, start_ready, iter}, {4'b1001, 16'd3});
    tick();
    chk("s1.after", {done, busy, start_ready}, 3'b001);
    chk_regs("s1.hold", 54, 42, 18, 28);

    // saturation and wrap at W=8
    sm8 = 1'b1; sv8 = 1'b1;
    tick();
    sv8 = 1'b0;
    chk("w8.accept", {busy8, ovf8, a8, b8}, {2'b10, 8'd0, 8'd100});
    tick();
    chk("w8.sat", {a8, b8, c8, d8, ovf8, done8}, {8'd127, 8'd10, 8'd101, 8'hFD, 2'b11});
    sm8 = 1'b0; sv8 = 1'b1;
    tick();
    sv8 = 1'b0;
    chk("w8.ovf_clear", {ovf8, busy8}, 2'b01);
    tick();
    chk("w8.wrap", {a8, ovf8, done8}, {8'hC8, 2'b11});

    // zero iterations
    seed(7, 8, 9, 10, 0);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("n0.done", {done, busy, iter}, {2'b10, 16'd0});
    chk_regs("n0.seed", 7, 8, 9, 10);
    tick();
    chk("n0.idle", {done, busy, start_ready}, 3'b001);

    // pause for two cycles after the first update
    seed(30, 20, 15, 5, 3);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_regs("pause.hold", 35, 15, 16, 27);
      chk("pause.state", {iter, busy, done}, {16'd1, 2'b10});
    end
    enable = 1'b1;
    tick();
    chk("pause.k4", {done, busy}, 2'b01);
    tick();
    chk("pause.k5", {done, busy, iter}, {2'b10, 16'd3});
    chk_regs("pause.final", 54, 42, 18, 28);

    // start ignored during run, then accepted during DONE
    seed(30, 20, 15, 5, 3);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    seed(900, 901, 902, 903, 9);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk_regs("ign.u2", 31, 37, 17, 32);
    chk("ign.iter", iter, 16'd2);
    tick();
    chk_regs("ign.u3", 54, 42, 18, 28);
    chk("ign.done", done, 1'b1);
    seed(1, 2, 3, 4, 2);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("redone.busy", {busy, done}, 2'b10);
    chk_regs("redone.seed", 1, 2, 3, 4);
    tick();
    tick();
    chk_regs("redone.u2", 18, 8, 5, 2);
    chk("redone.done", done, 1'b1);

    // reset in the middle of a run
    seed(30, 20, 15, 5, 5);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_regs("rst.regs", 0, 0, 0, 0);
    chk("rst.flags", {busy, done, ovf, start_ready, iter}, {4'b0001, 16'd0});
    tick();
    chk("rst.nodone", {done, busy}, 2'b00);
    seed(30, 20, 15, 5, 3);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_regs("rst.fresh", 54, 42, 18, 28);
    chk("rst.fresh_done", {done, ovf}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
